// File: rtl/bridge_pkg.sv
// ============================================================================
// Module : bridge_pkg
// Brief  : Shared AHB2APB bridge constants (transfer codes, sizes, slave map)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bridge_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] BYTE     = 3'b000;
  localparam logic [2:0] HALFWORD = 3'b001;
  localparam logic [2:0] WORD     = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [31:0] DEF_SLV0_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV1_BASE = 32'h8400_0000;
  localparam logic [31:0] DEF_SLV2_BASE = 32'h8800_0000;

  localparam int NUM_SLV = 3;

  // Sizes wider than a word are caught separately; only natural alignment is tested here.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lsb);
    return ((size == HALFWORD) && addr_lsb[0]) ||
           ((size == WORD) && (addr_lsb != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slave_if_if.sv
// ============================================================================
// Module : ahb_slave_bus_if
// Brief  : AHB-side and controller-side signal bundle of the bridge front end
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ahb_slave_bus_if;

  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Preadyout;
  logic [31:0] Prdata;

  logic        valid;
  logic [31:0] Haddr0;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata0;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic        Hwritereg;
  logic [2:0]  Hsize_reg;
  logic [2:0]  temp_sel;
  logic        Hreadyout;
  logic        Hresp;
  logic [31:0] Hrdata;

  modport slave (
    input  Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin, Preadyout, Prdata,
    output valid, Haddr0, Haddr1, Haddr2, Hwdata0, Hwdata1, Hwdata2,
           Hwritereg, Hsize_reg, temp_sel, Hreadyout, Hresp, Hrdata
  );

  modport master (
    output Htrans, Hwrite, Hsize, Haddr, Hwdata, Hreadyin, Preadyout, Prdata,
    input  valid, Haddr0, Haddr1, Haddr2, Hwdata0, Hwdata1, Hwdata2,
           Hwritereg, Hsize_reg, temp_sel, Hreadyout, Hresp, Hrdata
  );

endinterface

`default_nettype wire

// File: rtl/ahb_addr_decode.sv
// ============================================================================
// Module : ahb_addr_decode
// Brief  : Combinational APB slave select decode and illegal-transfer flag
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_addr_decode
  import bridge_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE
) (
  input  wire logic [5:0] i_addr_region,
  input  wire logic [1:0] i_addr_lsb,
  input  wire logic [2:0] i_hsize,
  input  wire logic       i_trans_active,
  input  wire logic       i_hreadyin,
  output logic [2:0]      o_sel_dec,
  output logic            o_illegal
);

  // Each slave owns a 64 MB window, so only the top six address bits matter.
  localparam logic [5:0] c_region [NUM_SLV] = '{SLV0_BASE[31:26], SLV1_BASE[31:26], SLV2_BASE[31:26]};

  logic w_unmapped;
  logic w_bad_size;

  generate
    for (genvar g = 0; g < NUM_SLV; g++) begin : g_sel
      assign o_sel_dec[g] = (i_addr_region == c_region[g]);
    end
  endgenerate

  assign w_unmapped = (o_sel_dec == 3'b000);
  assign w_bad_size = (i_hsize > WORD) || misaligned(i_hsize, i_addr_lsb);
  assign o_illegal  = i_trans_active && i_hreadyin && (w_unmapped || w_bad_size);

endmodule

`default_nettype wire

// File: rtl/ahb_slave_if.sv
// ============================================================================
// Module : ahb_slave_if
// Brief  : AHB-Lite slave front end: qualify, decode, pipeline, ERROR response
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_slave_if
  import bridge_pkg::*;
#(
  parameter logic [31:0] SLV0_BASE = DEF_SLV0_BASE,
  parameter logic [31:0] SLV1_BASE = DEF_SLV1_BASE,
  parameter logic [31:0] SLV2_BASE = DEF_SLV2_BASE
) (
  input  wire logic       Hclk,
  input  wire logic       Hresetn,
  ahb_slave_bus_if.slave  bus
);

  localparam logic [1:0] c_st_okay = 2'd0;
  localparam logic [1:0] c_st_err1 = 2'd1;
  localparam logic [1:0] c_st_err2 = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic [2:0]  w_sel_dec;
  logic        w_illegal;
  logic        w_hreadyout;
  logic        w_hresp;

  logic [31:0] r_haddr0;
  logic [31:0] r_haddr1;
  logic [31:0] r_haddr2;
  logic [31:0] r_hwdata0;
  logic [31:0] r_hwdata1;
  logic [31:0] r_hwdata2;
  logic        r_hwritereg;
  logic [2:0]  r_hsize_reg;
  logic [2:0]  r_temp_sel;

  ahb_addr_decode #(
    .SLV0_BASE (SLV0_BASE),
    .SLV1_BASE (SLV1_BASE),
    .SLV2_BASE (SLV2_BASE)
  ) u_decode (
    .i_addr_region  (bus.Haddr[31:26]),
    .i_addr_lsb     (bus.Haddr[1:0]),
    .i_hsize        (bus.Hsize),
    .i_trans_active (bus.Htrans[1]),
    .i_hreadyin     (bus.Hreadyin),
    .o_sel_dec      (w_sel_dec),
    .o_illegal      (w_illegal)
  );

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_haddr0    <= '0;
      r_haddr1    <= '0;
      r_haddr2    <= '0;
      r_hwdata0   <= '0;
      r_hwdata1   <= '0;
      r_hwdata2   <= '0;
      r_hwritereg <= 1'b0;
      r_hsize_reg <= '0;
      r_temp_sel  <= '0;
    end else if (bus.Hreadyin) begin
      r_haddr0    <= bus.Haddr;
      r_haddr1    <= r_haddr0;
      r_haddr2    <= r_haddr1;
      r_hwdata0   <= bus.Hwdata;
      r_hwdata1   <= r_hwdata0;
      r_hwdata2   <= r_hwdata1;
      r_hwritereg <= bus.Hwrite;
      r_hsize_reg <= bus.Hsize;
      r_temp_sel  <= w_sel_dec;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= c_st_okay;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ERR1 always advances: HREADYOUT is low there, so the bus HREADY may be low too.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_okay: if (w_illegal) w_next_state = c_st_err1;
      c_st_err1: w_next_state = c_st_err2;
      c_st_err2: w_next_state = w_illegal ? c_st_err1 : c_st_okay;
      default:   w_next_state = c_st_okay;
    endcase
  end

  always_comb begin
    w_hreadyout = 1'b1;
    w_hresp     = HRESP_OKAY;
    if (Hresetn) begin
      case (r_state)
        c_st_okay: w_hreadyout = bus.Preadyout;
        c_st_err1: begin
          w_hreadyout = 1'b0;
          w_hresp     = HRESP_ERROR;
        end
        c_st_err2: w_hresp = HRESP_ERROR;
        default:   w_hreadyout = 1'b1;
      endcase
    end
  end

  assign bus.valid     = bus.Hreadyin && bus.Htrans[1] && !w_illegal && (r_state == c_st_okay);
  assign bus.Haddr0    = r_haddr0;
  assign bus.Haddr1    = r_haddr1;
  assign bus.Haddr2    = r_haddr2;
  assign bus.Hwdata0   = r_hwdata0;
  assign bus.Hwdata1   = r_hwdata1;
  assign bus.Hwdata2   = r_hwdata2;
  assign bus.Hwritereg = r_hwritereg;
  assign bus.Hsize_reg = r_hsize_reg;
  assign bus.temp_sel  = r_temp_sel;
  assign bus.Hreadyout = w_hreadyout;
  assign bus.Hresp     = w_hresp;
  assign bus.Hrdata    = bus.Prdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_if.sv
// ============================================================================
// Module : tb_ahb_slave_if
// Brief  : Vector-table and scoreboard bench for the AHB slave front end
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_slave_if;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BY = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000;
  localparam logic [2:0] SZ_H = 3'b001;
  localparam logic [2:0] SZ_W = 3'b010;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdyin;
    logic        prdy;
    logic        valid;
    logic        hro;
    logic        hresp;
    logic [31:0] a0, a1, a2, wd0;
    logic [2:0]  tsel;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        hro;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] a0, a1, a2, wd0;
    logic [2:0]  tsel;
  } exp_t;

  logic Hclk;
  logic Hresetn;
  int   checks;
  int   errors;
  vec_t vecs[$];
  exp_t exp_q[$];

  ahb_slave_bus_if bus ();

  ahb_slave_if dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] trans, input logic write, input logic [2:0] size,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic rdyin,
                     input logic prdy, input logic valid, input logic hro, input logic hresp,
                     input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                     input logic [31:0] wd0, input logic [2:0] tsel);
    vec_t v;
    v.trans = trans; v.write = write; v.size = size; v.addr = addr; v.wdata = wdata;
    v.rdyin = rdyin; v.prdy = prdy; v.valid = valid; v.hro = hro; v.hresp = hresp;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd0 = wd0; v.tsel = tsel;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [1:0] trans, input logic write, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic rdyin,
                       input logic prdy, input logic [31:0] prdata);
    bus.Htrans = trans; bus.Hwrite = write; bus.Hsize = size; bus.Haddr = addr;
    bus.Hwdata = wdata; bus.Hreadyin = rdyin; bus.Preadyout = prdy; bus.Prdata = prdata;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_haddr0"},  bus.Haddr0, 32'h0);
    chk({tag, "_haddr1"},  bus.Haddr1, 32'h0);
    chk({tag, "_haddr2"},  bus.Haddr2, 32'h0);
    chk({tag, "_hwdata0"}, bus.Hwdata0, 32'h0);
    chk({tag, "_hwdata1"}, bus.Hwdata1, 32'h0);
    chk({tag, "_hwdata2"}, bus.Hwdata2, 32'h0);
    chk({tag, "_hwritereg"}, {31'h0, bus.Hwritereg}, 32'h0);
    chk({tag, "_hsize_reg"}, {29'h0, bus.Hsize_reg}, 32'h0);
    chk({tag, "_temp_sel"},  {29'h0, bus.temp_sel}, 32'h0);
    chk({tag, "_hreadyout"}, {31'h0, bus.Hreadyout}, 32'h1);
    chk({tag, "_hresp"},     {31'h0, bus.Hresp}, 32'h0);
  endtask

  initial begin
    exp_t e;
    exp_t got;
    checks = 0;
    errors = 0;

    // Reset, back-to-back writes, unmapped/misaligned/oversize errors, ERR2 acceptance, BUSY and wait states.
    add(NS,1,SZ_W,32'h8000_0004,32'h0,       1,1, 1,1,0, 32'h0,         32'h0,         32'h0,         32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'hDEADBEEF,1,1, 0,1,0, 32'h8000_0004, 32'h0,         32'h0,         32'h0,         3'b001);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,0, 32'h0,         32'h8000_0004, 32'h0,         32'hDEADBEEF,  3'b000);
    add(NS,1,SZ_W,32'h8000_0000,32'h0,       1,1, 1,1,0, 32'h0,         32'h0,         32'h8000_0004, 32'h0,         3'b000);
    add(NS,1,SZ_W,32'h8400_0000,32'h1111_1111,1,1,1,1,0, 32'h8000_0000, 32'h0,         32'h0,         32'h0,         3'b001);
    add(NS,1,SZ_W,32'h8800_0000,32'h2222_2222,1,1,1,1,0, 32'h8400_0000, 32'h8000_0000, 32'h0,         32'h1111_1111, 3'b010);
    add(ID,0,SZ_W,32'h0,        32'h3333_3333,1,1,0,1,0, 32'h8800_0000, 32'h8400_0000, 32'h8000_0000, 32'h2222_2222, 3'b100);
    add(NS,0,SZ_W,32'h9000_0000,32'h0,       1,1, 0,1,0, 32'h0,         32'h8800_0000, 32'h8400_0000, 32'h3333_3333, 3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       0,1, 0,0,1, 32'h9000_0000, 32'h0,         32'h8800_0000, 32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,1, 32'h9000_0000, 32'h0,         32'h8800_0000, 32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,0, 32'h0,         32'h9000_0000, 32'h0,         32'h0,         3'b000);
    add(NS,0,SZ_W,32'h8000_0002,32'h0,       1,1, 0,1,0, 32'h0,         32'h0,         32'h9000_0000, 32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       0,1, 0,0,1, 32'h8000_0002, 32'h0,         32'h0,         32'h0,         3'b001);
    add(NS,0,SZ_H,32'h8400_0001,32'h0,       1,1, 0,1,1, 32'h8000_0002, 32'h0,         32'h0,         32'h0,         3'b001);
    add(ID,0,SZ_W,32'h0,        32'h0,       0,1, 0,0,1, 32'h8400_0001, 32'h8000_0002, 32'h0,         32'h0,         3'b010);
    add(NS,1,SZ_W,32'h8000_0008,32'h0,       1,1, 0,1,1, 32'h8400_0001, 32'h8000_0002, 32'h0,         32'h0,         3'b010);
    add(NS,1,SZ_W,32'h8000_0008,32'h0,       1,1, 1,1,0, 32'h8000_0008, 32'h8400_0001, 32'h8000_0002, 32'h0,         3'b001);
    add(ID,0,SZ_W,32'h0,        32'hAAAA_5555,1,0,0,0,0, 32'h8000_0008, 32'h8000_0008, 32'h8400_0001, 32'h0,         3'b001);
    add(BY,1,SZ_W,32'h8000_000C,32'h0,       1,1, 0,1,0, 32'h0,         32'h8000_0008, 32'h8000_0008, 32'hAAAA_5555, 3'b000);
    add(SQ,1,SZ_W,32'h8000_0010,32'h0,       0,1, 0,1,0, 32'h8000_000C, 32'h0,         32'h8000_0008, 32'h0,         3'b001);
    add(SQ,1,SZ_W,32'h8000_0010,32'h1234,    0,1, 0,1,0, 32'h8000_000C, 32'h0,         32'h8000_0008, 32'h0,         3'b001);
    add(SQ,1,SZ_W,32'h8000_0010,32'h0,       1,1, 1,1,0, 32'h8000_000C, 32'h0,         32'h8000_0008, 32'h0,         3'b001);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,0, 32'h8000_0010, 32'h8000_000C, 32'h0,         32'h0,         3'b001);
    add(NS,0,3'b011,32'h8000_0000,32'h0,     1,1, 0,1,0, 32'h0,         32'h8000_0010, 32'h8000_000C, 32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,0,1, 32'h8000_0000, 32'h0,         32'h8000_0010, 32'h0,         3'b001);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,1, 32'h0,         32'h8000_0000, 32'h0,         32'h0,         3'b000);
    add(ID,0,SZ_W,32'h0,        32'h0,       1,1, 0,1,0, 32'h0,         32'h0,         32'h8000_0000, 32'h0,         3'b000);

    Hresetn = 1'b0;
    drive(ID, 1'b0, SZ_W, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2;
    chk_reset("por");
    @(posedge Hclk);
    #1 Hresetn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Hclk);
      #1;
      drive(vecs[i].trans, vecs[i].write, vecs[i].size, vecs[i].addr, vecs[i].wdata,
            vecs[i].rdyin, vecs[i].prdy, 32'hC0DE_0000 | 32'(i));
      e.valid = vecs[i].valid; e.hro = vecs[i].hro; e.hresp = vecs[i].hresp;
      e.hrdata = 32'hC0DE_0000 | 32'(i);
      e.a0 = vecs[i].a0; e.a1 = vecs[i].a1; e.a2 = vecs[i].a2;
      e.wd0 = vecs[i].wd0; e.tsel = vecs[i].tsel;
      exp_q.push_back(e);
      #4;
      got = exp_q.pop_front();
      chk($sformatf("v%0d_valid", i),     {31'h0, bus.valid},     {31'h0, got.valid});
      chk($sformatf("v%0d_hreadyout", i), {31'h0, bus.Hreadyout}, {31'h0, got.hro});
      chk($sformatf("v%0d_hresp", i),     {31'h0, bus.Hresp},     {31'h0, got.hresp});
      chk($sformatf("v%0d_hrdata", i),    bus.Hrdata,             got.hrdata);
      chk($sformatf("v%0d_haddr0", i),    bus.Haddr0,             got.a0);
      chk($sformatf("v%0d_haddr1", i),    bus.Haddr1,             got.a1);
      chk($sformatf("v%0d_haddr2", i),    bus.Haddr2,             got.a2);
      chk($sformatf("v%0d_hwdata0", i),   bus.Hwdata0,            got.wd0);
      chk($sformatf("v%0d_temp_sel", i),  {29'h0, bus.temp_sel},  {29'h0, got.tsel});
    end

    // Control registration and the full write-data pipeline.
    @(posedge Hclk); #1;
    drive(NS, 1'b1, SZ_H, 32'h8400_0002, 32'h0, 1'b1, 1'b1, 32'h0);
    #4 chk("h0_valid_half", {31'h0, bus.valid}, 32'h1);
    @(posedge Hclk); #1;
    drive(NS, 1'b0, SZ_B, 32'h8800_0003, 32'h5A5A_0001, 1'b1, 1'b1, 32'h0);
    #4;
    chk("h1_valid_byte", {31'h0, bus.valid}, 32'h1);
    chk("h1_hwritereg",  {31'h0, bus.Hwritereg}, 32'h1);
    chk("h1_hsize_reg",  {29'h0, bus.Hsize_reg}, {29'h0, SZ_H});
    chk("h1_temp_sel",   {29'h0, bus.temp_sel}, 32'h2);
    @(posedge Hclk); #1;
    drive(ID, 1'b0, SZ_W, 32'h0, 32'h5A5A_0002, 1'b1, 1'b1, 32'h0);
    #4;
    chk("h2_hwritereg", {31'h0, bus.Hwritereg}, 32'h0);
    chk("h2_hsize_reg", {29'h0, bus.Hsize_reg}, {29'h0, SZ_B});
    chk("h2_temp_sel",  {29'h0, bus.temp_sel}, 32'h4);
    chk("h2_hwdata0",   bus.Hwdata0, 32'h5A5A_0001);
    @(posedge Hclk); #1;
    drive(ID, 1'b0, SZ_W, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    #4;
    chk("h3_hwdata1", bus.Hwdata1, 32'h5A5A_0001);
    @(posedge Hclk); #1;
    #4;
    chk("h4_hwdata2", bus.Hwdata2, 32'h5A5A_0001);
    chk("h4_hwdata1", bus.Hwdata1, 32'h5A5A_0002);
    chk("h4_haddr2",  bus.Haddr2,  32'h8800_0003);

    // Asynchronous reset between edges with the pipeline loaded.
    #2;
    bus.Preadyout = 1'b0;
    Hresetn = 1'b0;
    #1;
    chk_reset("mid");
    @(posedge Hclk); #1;
    Hresetn = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
